alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Push-button command sequencer feeding operands and an opcode to an external ALU.
// Optional macro ALU_SEQ_DIVZERO_GUARD_EN suppresses divide/modulo-by-zero requests and flags err.
module alu_cmd_sequencer #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic         btn_enter,
    input  logic         btn_next,
    input  logic         btn_prev,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_control,
    output logic         alu_valid,
    input  logic         alu_ready,
    input  logic [N-1:0] alu_result,
    input  logic [3:0]   alu_flags,
    output logic [N-1:0] result_q,
    output logic [3:0]   flags_q,
    output logic [2:0]   state_q,
    output logic         err
);

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] OP_MAX = 4'd9;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    state_t state, state_d;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] sync_1, sync_2, deb, deb_prev;
    logic [CNT_W-1:0]   cnt [NUM_BTN];
    logic [NUM_BTN-1:0] press_c;
    logic               enter_c, next_c, prev_c, div0_c;

    logic [N-1:0] alu_a_d, alu_b_d, result_d;
    logic [3:0]   alu_control_d, flags_d;
    logic         err_d, alu_valid_d;

    assign btn_raw = {btn_prev, btn_next, btn_enter};

    // Synchronise each button, then accept a new level only after it holds for DEBOUNCE_CYCLES samples
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_1   <= '1;
            sync_2   <= '1;
            deb      <= '1;
            deb_prev <= '1;
            for (int i = 0; i < int'(NUM_BTN); i++) cnt[i] <= '0;
        end else begin
            sync_1   <= btn_raw;
            sync_2   <= sync_1;
            deb_prev <= deb;
            for (int i = 0; i < int'(NUM_BTN); i++) begin
                if (sync_2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    cnt[i] <= '0;
                    deb[i] <= sync_2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle press on each debounced falling edge; enter beats next beats prev
    assign press_c = deb_prev & ~deb;
    assign enter_c = press_c[0];
    assign next_c  = press_c[1] & ~press_c[0];
    assign prev_c  = press_c[2] & ~press_c[1] & ~press_c[0];

`ifdef ALU_SEQ_DIVZERO_GUARD_EN
    assign div0_c = ((alu_control == 4'd7) || (alu_control == 4'd9)) && (alu_b == '0);
`else
    assign div0_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= LOAD_A;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
            alu_valid   <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            err         <= 1'b0;
        end else begin
            state       <= state_d;
            alu_a       <= alu_a_d;
            alu_b       <= alu_b_d;
            alu_control <= alu_control_d;
            alu_valid   <= alu_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            err         <= err_d;
        end
    end

    always_comb begin
        state_d       = state;
        alu_a_d       = alu_a;
        alu_b_d       = alu_b;
        alu_control_d = alu_control;
        result_d      = result_q;
        flags_d       = flags_q;
        err_d         = err;
        case (state)
            LOAD_A: begin
                if (enter_c) begin
                    alu_a_d = sw;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (enter_c) begin
                    alu_b_d = sw;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (enter_c) begin
                    state_d = EXEC;
                end else if (next_c) begin
                    alu_control_d = (alu_control >= OP_MAX) ? 4'd0 : alu_control + 4'd1;
                end else if (prev_c) begin
                    alu_control_d = (alu_control == 4'd0) ? OP_MAX : alu_control - 4'd1;
                end
            end
            EXEC: begin
                if (div0_c) begin
                    err_d   = 1'b1;
                    state_d = SHOW;
                end else if (alu_valid && alu_ready) begin
                    result_d = alu_result;
                    flags_d  = alu_flags;
                    state_d  = SHOW;
                end
            end
            SHOW: begin
                if (enter_c) begin
                    err_d   = 1'b0;
                    state_d = LOAD_A;
                end
            end
            default: state_d = LOAD_A;
        endcase
        // Operands and opcode cannot change on EXEC entry, so div0_c already reflects the issued request
        alu_valid_d = (state_d == EXEC) && !div0_c;
    end

    assign state_q = 3'(state);

endmodule
